// File: rtl/piso_tx.sv
// Parallel-in, serial-out transmitter: takes a WIDTH-bit word on a valid/ready
// handshake and shifts it out one bit per clock with frame_start/done markers.
module piso_tx #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] parallel_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             frame_start,
    output logic             done
);
    localparam int unsigned CNT_W = $clog2(WIDTH);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] shreg;
    logic             last_bit;
    logic             handshake;

    always_comb begin
        last_bit   = (state == SHIFT) && (count == CNT_W'(WIDTH - 1));
        load_ready = !rst && ((state == IDLE) || last_bit);
        handshake  = load_valid && load_ready;
    end

    // shreg holds the bits still to be sent, next one at the outgoing end.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            count        <= '0;
            shreg        <= '0;
            serial_out   <= 1'b0;
            serial_valid <= 1'b0;
            frame_start  <= 1'b0;
            done         <= 1'b0;
        end else if (handshake) begin
            state        <= SHIFT;
            count        <= '0;
            serial_valid <= 1'b1;
            frame_start  <= 1'b1;
            done         <= 1'b0;
            if (MSB_FIRST) begin
                serial_out <= parallel_in[WIDTH-1];
                shreg      <= parallel_in << 1;
            end else begin
                serial_out <= parallel_in[0];
                shreg      <= parallel_in >> 1;
            end
        end else if (state == SHIFT) begin
            if (last_bit) begin
                state        <= IDLE;
                count        <= '0;
                serial_out   <= 1'b0;
                serial_valid <= 1'b0;
                frame_start  <= 1'b0;
                done         <= 1'b0;
            end else begin
                count       <= count + CNT_W'(1);
                frame_start <= 1'b0;
                done        <= (count == CNT_W'(WIDTH - 2));
                if (MSB_FIRST) begin
                    serial_out <= shreg[WIDTH-1];
                    shreg      <= shreg << 1;
                end else begin
                    serial_out <= shreg[0];
                    shreg      <= shreg >> 1;
                end
            end
        end
    end
endmodule

// File: doc/piso_tx.md
# piso_tx

Parallel-in, serial-out transmitter: accepts a WIDTH-bit word over a valid/ready handshake and drives it out one bit per clock with a qualifying valid strobe. It is the transmit end of the team's serial link. With MSB_FIRST=1, a receiver that shifts each new bit in at the LSB holds the original word after WIDTH valid bits. Words can be sent back-to-back with no idle cycle between frames.

## Interface
- WIDTH, 8: word width in bits; legal range ≥ 2.
- MSB_FIRST, 1: 1 sends bit WIDTH-1 first; 0 sends bit 0 first.

- clk  input  1  rising-edge clock; sole clock domain.
- rst  input  1  synchronous, active-high reset.
- parallel_in  input  WIDTH  word to transmit; sampled only on handshake.
- load_valid  input  1  producer offers parallel_in.
- load_ready  output  1  block can accept a word this cycle.
- serial_out  output  1  current serial bit (registered).
- serial_valid  output  1  serial_out carries a frame bit (registered).
- frame_start  output  1  high with the first bit of each frame (registered).
- done  output  1  high with the last bit of each frame (registered).

## Operation
- Two states:
  - IDLE: no frame in flight.
  - SHIFT: a frame is in flight. A bit counter holds the index (0..WIDTH-1) of the bit currently on serial_out.
- A handshake occurs when load_valid && load_ready is high at a rising edge. On that edge:
  - the word is captured;
  - the first bit goes to serial_out;
  - serial_valid=1, frame_start=1, and the counter is set to 0;
  - the state becomes SHIFT.
- In SHIFT, each edge advances to the next bit and increments the counter. frame_start is 0 except on the first bit.
- Counter = WIDTH-1 means the last bit is on serial_out:
  - done=1;
  - load_ready=1.
- Next edge after the last bit:
  - with a handshake: the new word's first bit follows immediately (no gap) and the state stays SHIFT;
  - without one: the state becomes IDLE, serial_valid=0, serial_out=0 and done=0.
- load_ready = !rst && (state==IDLE || counter==WIDTH-1). It is combinational and does not depend on load_valid.
- parallel_in is ignored whenever no handshake occurs. A word held on load_valid during a frame is accepted only on the last-bit cycle.
- In IDLE, serial_out=0, serial_valid=0, frame_start=0 and done=0.
- Reset at any point, including mid-frame:
  - the frame is discarded;
  - the next cycle shows IDLE with every registered output 0;
  - load_valid is ignored while rst=1;
  - load_ready is 0 during rst and 1 in the first cycle after rst falls.

## Timing
- Reset values: serial_out=0, serial_valid=0, frame_start=0, done=0, state IDLE, counter 0.
- Latency: the first bit is valid in the cycle after the handshake edge. The last bit is valid WIDTH cycles after the handshake edge.
- Throughput: one word per WIDTH cycles when load_valid is held high; serial_valid stays continuously high.
- Within a frame, serial_valid is high for exactly WIDTH consecutive cycles. frame_start and done are each high for exactly one of them.

## Structure
- No shared package needed.
- Local constant CNT_W = $clog2(WIDTH); the state encoding is a local two-value enum.
- Single module; no sub-module is warranted (one shift register, one counter, two-state FSM).

## Test plan
- Single frame: after reset, WIDTH=8, MSB_FIRST=1, load 8'hA5 → serial_out 1,0,1,0,0,1,0,1 over 8 cycles; frame_start on cycle 1, done on cycle 8; then serial_valid=0 and load_ready=1.
- Back-to-back: load_valid held high, with 8'hA5 then 8'h3C → 16 contiguous serial_valid cycles; bit 9 = 0 (MSB of 3C); load_ready high only in IDLE and on cycles 8/16.
- LSB-first: MSB_FIRST=0, load 8'h01 → serial_out 1,0,0,0,0,0,0,0.
- Handshake stall: present 8'hFF on cycle 3 of an active frame → not accepted until the last-bit cycle; its first bit appears right after the current frame's done.
- Mid-frame reset: assert rst while bit 3 is on serial_out → next cycle all outputs 0; load_ready=0 while rst is high, then 1; a fresh 8'h81 then transmits correctly.
- Loopback: feed serial_out into a shift register that shifts in at the LSB, gated by serial_valid, and send random words for 1000 frames → the register equals each sent word in the cycle after done.
